// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state enum, datapath widths, legal round counts and the
// FIPS-197 appendix C vectors (keys are left-aligned in 256 bits).
package aes_seq_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int RK_IDX_W    = 4;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } seq_state_t;

    function automatic bit is_legal_nr(input int nr);
        return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
    endfunction

    // FIPS-197 C.1 (AES-128) and C.3 (AES-256), same plaintext.
    localparam logic [255:0] FIPS_C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] FIPS_C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;

endpackage

// File: rtl/aes_seq_perf_cnt.sv
// Performance counters for the AES round sequencer: completed blocks and DONE stall cycles.
// Latency: counters update on the clock edge after the qualifying cycle.
// Backpressure: none; observes the output handshake only.
// Ports: clk_in/rst_in (async active-high), done_i (sequencer in DONE), out_ready_i (sink ready),
// blk_count_o (handshakes, wraps mod 2^32), stall_count_o (DONE & !ready cycles, saturating).
// Present only when AES_SEQ_PERF_CNT_EN is defined, so the default build carries no orphan module.
`ifdef AES_SEQ_PERF_CNT_EN
module aes_seq_perf_cnt (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        done_i,
    input  logic        out_ready_i,
    output logic [31:0] blk_count_o,
    output logic [31:0] stall_count_o
);

    logic [31:0] blk_q, blk_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        blk_d   = blk_q;
        stall_d = stall_q;
        if (done_i && out_ready_i) begin
            blk_d = blk_q + 32'd1;
        end
        if (done_i && !out_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            blk_q   <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            blk_q   <= blk_d;
            stall_q <= stall_d;
        end
    end

    assign blk_count_o   = blk_q;
    assign stall_count_o = stall_q;

endmodule
`endif

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: one shared round unit reused for all NR rounds of a 128-bit block.
// Latency: out_valid_out rises NR__ROUNDS cycles after the accept edge; block period NR__ROUNDS+2.
// Backpressure: output held in DONE until out_ready_in; no new block accepted until back in IDLE.
// Ports: valid/ready block source (plain_txt_in) and sink (cipher_txt_out); round-key lookup
// (rk_idx_out -> rk_in, same cycle); round unit (rnd_state_out/rnd_last_out -> rnd_result_in).
// Optional macro AES_SEQ_PERF_CNT_EN adds blk_count_out and stall_count_out.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NR__ROUNDS               = 14,
    parameter int NB__BLOCK_LENGTH_IN_TEXT = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   key_ready_in,
    input  logic                   in_valid_in,
    output logic                   in_ready_out,
    input  logic [AES_BLOCK_W-1:0] plain_txt_in,
    output logic                   out_valid_out,
    input  logic                   out_ready_in,
    output logic [AES_BLOCK_W-1:0] cipher_txt_out,
    output logic                   busy_out,
    output logic [RK_IDX_W-1:0]    rk_idx_out,
    input  logic [AES_BLOCK_W-1:0] rk_in,
    output logic [AES_BLOCK_W-1:0] rnd_state_out,
    output logic                   rnd_last_out,
    input  logic [AES_BLOCK_W-1:0] rnd_result_in
`ifdef AES_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            blk_count_out,
    output logic [31:0]            stall_count_out
`endif
);

    if (!is_legal_nr(NR__ROUNDS) || (NB__BLOCK_LENGTH_IN_TEXT * 32 != AES_BLOCK_W)) begin : g_bad_cfg
        $error("aes_round_sequencer: NR__ROUNDS must be 10, 12 or 14 and the block 128 bits");
    end

    localparam logic [RK_IDX_W-1:0] LAST_MID_ROUND = RK_IDX_W'(NR__ROUNDS - 1);
    localparam logic [RK_IDX_W-1:0] FINAL_KEY_IDX  = RK_IDX_W'(NR__ROUNDS);

    seq_state_t             state_q, state_d;
    logic [AES_BLOCK_W-1:0] state_reg_q, state_reg_d;
    logic [RK_IDX_W-1:0]    round_cnt_q, round_cnt_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            state_reg_q <= '0;
            round_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            state_reg_q <= state_reg_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        state_reg_d   = state_reg_q;
        round_cnt_d   = round_cnt_q;
        in_ready_out  = 1'b0;
        out_valid_out = 1'b0;
        busy_out      = 1'b1;
        rk_idx_out    = round_cnt_q;
        rnd_last_out  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_out   = 1'b0;
                rk_idx_out = '0;
                // The state register is already IDLE during reset; masking keeps
                // in_ready_out at 0 while reset is held even if keys are ready.
                in_ready_out = key_ready_in & ~rst_in;
                if (in_valid_in && key_ready_in) begin
                    // Initial AddRoundKey with key 0 happens on the way in.
                    state_reg_d = plain_txt_in ^ rk_in;
                    round_cnt_d = RK_IDX_W'(1);
                    state_d     = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_reg_d = rnd_result_in ^ rk_in;
                round_cnt_d = round_cnt_q + RK_IDX_W'(1);
                if (round_cnt_q == LAST_MID_ROUND) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                rk_idx_out   = FINAL_KEY_IDX;
                rnd_last_out = 1'b1;
                state_reg_d  = rnd_result_in ^ rk_in;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                out_valid_out = 1'b1;
                if (out_ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cipher_txt_out = state_reg_q;
    assign rnd_state_out  = state_reg_q;

`ifdef AES_SEQ_PERF_CNT_EN
    aes_seq_perf_cnt u_perf_cnt (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .done_i        (state_q == ST_DONE),
        .out_ready_i   (out_ready_in),
        .blk_count_o   (blk_count_out),
        .stall_count_o (stall_count_out)
    );
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: AES-256 instance (a_*) and AES-128 instance (b_*),
// each served by a reference round unit and key store built from plain AES arithmetic.
module tb_aes_round_sequencer;
    import aes_seq_pkg::*;

    typedef logic [14:0][127:0] rks_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic         a_key_ready, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_last;
    logic [127:0] a_pt, a_ct, a_rk, a_st, a_res;
    logic [3:0]   a_idx;
    logic         b_key_ready, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_last;
    logic [127:0] b_pt, b_ct, b_rk, b_st, b_res;
    logic [3:0]   b_idx;
    rks_t         a_rks, b_rks;
    logic [255:0] a_key, b_key;
`ifdef AES_SEQ_PERF_CNT_EN
    logic [31:0] a_blk, a_stall, b_blk, b_stall;
`endif

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p ^= t;
            t = xt(t);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr + 4*((c+rr) % 4)];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (last) begin
                r[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
        end
        return r;
    endfunction

    function automatic rks_t expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rks_t        rk;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        rk   = '0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xt(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk,
                                             input logic [127:0] pt);
        rks_t         rk;
        logic [127:0] s;
        int           nr;
        nr = nk + 6;
        rk = expand_key(key, nk);
        s  = pt ^ rk[0];
        for (int r = 1; r < nr; r++) s = aes_round(s, 1'b0) ^ rk[r];
        return aes_round(s, 1'b1) ^ rk[nr];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- external round units and key stores ----------------
    assign a_rk  = a_rks[a_idx];
    assign a_res = aes_round(a_st, a_last);
    assign b_rk  = b_rks[b_idx];
    assign b_res = aes_round(b_st, b_last);

    aes_round_sequencer #(.NR__ROUNDS(14), .NB__BLOCK_LENGTH_IN_TEXT(4)) dut14 (
        .clk_in(clk), .rst_in(rst), .key_ready_in(a_key_ready),
        .in_valid_in(a_in_valid), .in_ready_out(a_in_ready), .plain_txt_in(a_pt),
        .out_valid_out(a_out_valid), .out_ready_in(a_out_ready), .cipher_txt_out(a_ct),
        .busy_out(a_busy), .rk_idx_out(a_idx), .rk_in(a_rk),
        .rnd_state_out(a_st), .rnd_last_out(a_last), .rnd_result_in(a_res)
`ifdef AES_SEQ_PERF_CNT_EN
        , .blk_count_out(a_blk), .stall_count_out(a_stall)
`endif
    );

    aes_round_sequencer #(.NR__ROUNDS(10), .NB__BLOCK_LENGTH_IN_TEXT(4)) dut10 (
        .clk_in(clk), .rst_in(rst), .key_ready_in(b_key_ready),
        .in_valid_in(b_in_valid), .in_ready_out(b_in_ready), .plain_txt_in(b_pt),
        .out_valid_out(b_out_valid), .out_ready_in(b_out_ready), .cipher_txt_out(b_ct),
        .busy_out(b_busy), .rk_idx_out(b_idx), .rk_in(b_rk),
        .rnd_state_out(b_st), .rnd_last_out(b_last), .rnd_result_in(b_res)
`ifdef AES_SEQ_PERF_CNT_EN
        , .blk_count_out(b_blk), .stall_count_out(b_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one block through dut14 and reports edges-from-accept to out_valid and the output.
    task automatic run14(input logic [127:0] pt, output int lat, output logic [127:0] ct);
        int w;
        w = 0;
        a_pt = pt; a_in_valid = 1'b1; #1;
        while (!a_in_ready && w < 50) begin tick(); w++; end
        if (!a_in_ready) begin lat = -1; ct = 'x; a_in_valid = 1'b0; return; end
        tick();
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 40) begin tick(); lat++; end
        ct = a_ct;
        a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
    endtask

    task automatic run10(input logic [127:0] pt, output int lat, output logic [127:0] ct);
        int w;
        w = 0;
        b_pt = pt; b_in_valid = 1'b1; #1;
        while (!b_in_ready && w < 50) begin tick(); w++; end
        if (!b_in_ready) begin lat = -1; ct = 'x; b_in_valid = 1'b0; return; end
        tick();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 40) begin tick(); lat++; end
        ct = b_ct;
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_ct !== 128'h0) begin n_fail++; $display("FAIL reset_cipher: got %h want 0", a_ct); end
        n_checks++; if (a_idx !== 4'd0) begin n_fail++; $display("FAIL reset_rk_idx: got %0d want 0", a_idx); end
        n_checks++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_last: got %b want 0", a_last); end
        n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_128: got %b want 0", b_in_ready); end
`ifdef AES_SEQ_PERF_CNT_EN
        n_checks++; if (a_blk !== 32'd0) begin n_fail++; $display("FAIL reset_blk_count: got %0d want 0", a_blk); end
        n_checks++; if (a_stall !== 32'd0) begin n_fail++; $display("FAIL reset_stall_count: got %0d want 0", a_stall); end
`endif
    endtask

    task automatic test_fips256();
        a_key = FIPS_C3_KEY; a_rks = expand_key(a_key, 8);
        n_checks++; if (aes_ref(a_key, 8, FIPS_PT) !== FIPS_C3_CT) begin n_fail++; $display("FAIL model_c3: got %h want %h", aes_ref(a_key, 8, FIPS_PT), FIPS_C3_CT); end
        a_pt = FIPS_PT; a_in_valid = 1'b1; #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL c3_in_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_idx !== 4'd0) begin n_fail++; $display("FAIL c3_idle_idx: got %0d want 0", a_idx); end
        tick();
        a_in_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            n_checks++; if (a_idx !== 4'(c + 1)) begin n_fail++; $display("FAIL c3_rk_idx: cycle %0d got %0d want %0d", c, a_idx, c + 1); end
            n_checks++; if (a_last !== (c == 13)) begin n_fail++; $display("FAIL c3_rnd_last: cycle %0d got %b want %b", c, a_last, c == 13); end
            n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL c3_early_valid: cycle %0d got %b want 0", c, a_out_valid); end
            tick();
        end
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL c3_latency: valid %b at 14 cycles, want 1", a_out_valid); end
        n_checks++; if (a_ct !== FIPS_C3_CT) begin n_fail++; $display("FAIL c3_cipher: got %h want %h", a_ct, FIPS_C3_CT); end
        a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL c3_busy_after: got %b want 0", a_busy); end
    endtask

    task automatic test_fips128();
        int lat;
        b_key = FIPS_C1_KEY; b_rks = expand_key(b_key, 4);
        b_pt = FIPS_PT; b_in_valid = 1'b1; #1;
        tick();
        b_in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (b_idx !== 4'(c + 1)) begin n_fail++; $display("FAIL c1_rk_idx: cycle %0d got %0d want %0d", c, b_idx, c + 1); end
            n_checks++; if (b_last !== (c == 9)) begin n_fail++; $display("FAIL c1_rnd_last: cycle %0d got %b want %b", c, b_last, c == 9); end
            tick();
        end
        n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL c1_latency: valid %b at 10 cycles, want 1", b_out_valid); end
        n_checks++; if (b_ct !== FIPS_C1_CT) begin n_fail++; $display("FAIL c1_cipher: got %h want %h", b_ct, FIPS_C1_CT); end
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL c1_busy_after: got %b want 0", b_busy); end
    endtask

    task automatic test_key_ready();
        logic [127:0] pt;
        int lat;
        pt = rnd128();
        a_key_ready = 1'b0; a_pt = pt; a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL keyrdy_in_ready: cycle %0d got %b want 0", i, a_in_ready); end
            n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL keyrdy_busy: cycle %0d got %b want 0", i, a_busy); end
            tick();
        end
        a_key_ready = 1'b1; #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL keyrdy_raise: got %b want 1", a_in_ready); end
        tick();
        a_in_valid = 1'b0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL keyrdy_accept: busy %b want 1", a_busy); end
        a_key_ready = 1'b0;  // dropping mid-block must not disturb the running block
        lat = 0;
        while (!a_out_valid && lat < 40) begin tick(); lat++; end
        n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL keyrdy_latency: got %0d want 14", lat); end
        n_checks++; if (a_ct !== aes_ref(a_key, 8, pt)) begin n_fail++; $display("FAIL keyrdy_cipher: got %h want %h", a_ct, aes_ref(a_key, 8, pt)); end
        a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
        a_key_ready = 1'b1;
    endtask

    task automatic test_stall();
        logic [127:0] pt1, pt2, exp1, exp2, ct;
        int lat;
`ifdef AES_SEQ_PERF_CNT_EN
        logic [31:0] stall0;
`endif
        pt1 = rnd128(); pt2 = rnd128();
        exp1 = aes_ref(a_key, 8, pt1); exp2 = aes_ref(a_key, 8, pt2);
        a_pt = pt1; a_in_valid = 1'b1; #1;
        tick();
        a_pt = pt2;  // second block presented while busy
        lat = 0;
        while (!a_out_valid && lat < 40) begin tick(); lat++; end
        n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL stall_latency: got %0d want 14", lat); end
`ifdef AES_SEQ_PERF_CNT_EN
        stall0 = a_stall;
`endif
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: cycle %0d got %b want 1", i, a_out_valid); end
            n_checks++; if (a_ct !== exp1) begin n_fail++; $display("FAIL stall_cipher: cycle %0d got %h want %h", i, a_ct, exp1); end
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", i, a_in_ready); end
            tick();
        end
`ifdef AES_SEQ_PERF_CNT_EN
        n_checks++; if (a_stall - stall0 !== 32'd20) begin n_fail++; $display("FAIL stall_count: delta %0d want 20", a_stall - stall0); end
`endif
        a_out_ready = 1'b1; tick(); a_out_ready = 1'b0; #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_idle_ready: got %b want 1", a_in_ready); end
        a_in_valid = 1'b0;
        run14(pt2, lat, ct);
        n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL stall_second_latency: got %0d want 14", lat); end
        n_checks++; if (ct !== exp2) begin n_fail++; $display("FAIL stall_second_cipher: got %h want %h", ct, exp2); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] ct;
        a_pt = rnd128(); a_in_valid = 1'b1; #1;
        tick();
        a_in_valid = 1'b0;
        repeat (6) tick();
        n_checks++; if (a_idx !== 4'd7) begin n_fail++; $display("FAIL rstmid_round: got %0d want 7", a_idx); end
        #2 rst = 1'b1; #1;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 0", a_in_ready); end
        n_checks++; if (a_idx !== 4'd0) begin n_fail++; $display("FAIL rstmid_rk_idx: got %0d want 0", a_idx); end
        n_checks++; if (a_ct !== 128'h0) begin n_fail++; $display("FAIL rstmid_cipher: got %h want 0", a_ct); end
        n_checks++; if (a_st !== 128'h0) begin n_fail++; $display("FAIL rstmid_rnd_state: got %h want 0", a_st); end
        n_checks++; if ({a_out_valid, a_last} !== 2'b00) begin n_fail++; $display("FAIL rstmid_valid_last: got %b want 00", {a_out_valid, a_last}); end
        #1 rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_partial: got %b want 0", a_out_valid); end
        run14(FIPS_PT, lat, ct);
        n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 14", lat); end
        n_checks++; if (ct !== FIPS_C3_CT) begin n_fail++; $display("FAIL rstmid_cipher_after: got %h want %h", ct, FIPS_C3_CT); end
    endtask

    task automatic test_random();
        logic [127:0] pt, ct;
        int lat;
        for (int i = 0; i < 4; i++) begin
            a_key = {rnd128(), rnd128()}; a_rks = expand_key(a_key, 8);
            pt = rnd128();
            run14(pt, lat, ct);
            n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL rand256_latency: blk %0d got %0d want 14", i, lat); end
            n_checks++; if (ct !== aes_ref(a_key, 8, pt)) begin n_fail++; $display("FAIL rand256_cipher: blk %0d got %h want %h", i, ct, aes_ref(a_key, 8, pt)); end
        end
        for (int i = 0; i < 3; i++) begin
            b_key = {rnd128(), 128'h0}; b_rks = expand_key(b_key, 4);
            pt = rnd128();
            run10(pt, lat, ct);
            n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL rand128_latency: blk %0d got %0d want 10", i, lat); end
            n_checks++; if (ct !== aes_ref(b_key, 4, pt)) begin n_fail++; $display("FAIL rand128_cipher: blk %0d got %h want %h", i, ct, aes_ref(b_key, 4, pt)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [3];
        logic [127:0] got [$];
        int acc_t [$];
        int cyc, k;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 3; i++) pts[i] = rnd128();
        cyc = 0; k = 0;
        a_out_ready = 1'b1; a_pt = pts[0]; a_in_valid = 1'b1;
        while (got.size() < 3 && cyc < 200) begin
            #1;
            if (a_out_valid && a_out_ready) got.push_back(a_ct);
            if (a_in_valid && a_in_ready) begin acc_t.push_back(cyc); k++; end
            tick();
            cyc++;
            if (k < 3) a_pt = pts[k];
            else a_in_valid = 1'b0;
        end
        a_out_ready = 1'b0; a_in_valid = 1'b0;
        n_checks++; if (got.size() !== 3 || acc_t.size() !== 3) begin n_fail++; $display("FAIL b2b_count: outputs %0d accepts %0d want 3", got.size(), acc_t.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_checks++; if (got[i] !== aes_ref(a_key, 8, pts[i])) begin n_fail++; $display("FAIL b2b_cipher: blk %0d got %h want %h", i, got[i], aes_ref(a_key, 8, pts[i])); end
            end
        end
        for (int i = 1; i < 3; i++) begin
            if (i < acc_t.size()) begin
                n_checks++; if (acc_t[i] - acc_t[i-1] !== 16) begin n_fail++; $display("FAIL b2b_period: gap %0d got %0d want 16", i, acc_t[i] - acc_t[i-1]); end
            end
        end
`ifdef AES_SEQ_PERF_CNT_EN
        n_checks++; if (a_blk !== 32'd3) begin n_fail++; $display("FAIL b2b_blk_count: got %0d want 3", a_blk); end
        n_checks++; if (a_stall !== 32'd0) begin n_fail++; $display("FAIL b2b_stall_count: got %0d want 0", a_stall); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        a_key_ready = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_pt = '0;
        b_key_ready = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_pt = '0;
        a_key = FIPS_C3_KEY; a_rks = expand_key(a_key, 8);
        b_key = FIPS_C1_KEY; b_rks = expand_key(b_key, 4);
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_fips256();
        test_fips128();
        test_key_ready();
        test_stall();
        test_reset_mid();
        test_random();
        a_key = FIPS_C3_KEY; a_rks = expand_key(a_key, 8);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
